// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller between the MEM stage
// and backing memory. Misses stall the pipeline while a line is evicted and/or fetched.
module dcache_ctrl #(
  parameter int NUM_LINES  = 16,
  parameter int MEM_LINE_W = 128
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [31:0]           addr_i,
  input  logic [31:0]           data_i,
  input  logic                  MemRd_i,
  input  logic                  MemWr_i,
  output logic [31:0]           data_o,
  output logic                  stall_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [31:0]           mem_addr_o,
  output logic [MEM_LINE_W-1:0] mem_wdata_o,
  input  logic [MEM_LINE_W-1:0] mem_rdata_i,
  input  logic                  mem_ack_i,
  output logic [31:0]           hit_cnt_o,
  output logic [31:0]           miss_cnt_o
);

  localparam int IW = $clog2(NUM_LINES);
  localparam int TW = 28 - IW;

  typedef enum logic [1:0] {IDLE, WBACK, ALLOC} state_t;

  state_t state, next_state;

  logic [NUM_LINES-1:0]  valid;
  logic [NUM_LINES-1:0]  dirty;
  logic [TW-1:0]         tag_arr  [NUM_LINES];
  logic [MEM_LINE_W-1:0] data_arr [NUM_LINES];

  logic [TW-1:0]         req_tag;
  logic [IW-1:0]         idx;
  logic [1:0]            word;
  logic [TW-1:0]         line_tag;
  logic [MEM_LINE_W-1:0] line;
  logic [31:0]           sel_word;
  logic                  req;
  logic                  hit;
  logic                  store_hit;
  logic                  replay;
  logic                  unused_bits;

  logic                  mem_req, mem_we;
  logic [31:0]           mem_addr;
  logic [MEM_LINE_W-1:0] mem_wdata;
  logic                  req_n, we_n;
  logic [31:0]           addr_n;
  logic [MEM_LINE_W-1:0] wdata_n;
  logic [31:0]           hit_cnt, miss_cnt;

  assign req_tag     = addr_i[31:4+IW];
  assign idx         = addr_i[3+IW:4];
  assign word        = addr_i[3:2];
  assign unused_bits = ^addr_i[1:0];

  assign line_tag  = tag_arr[idx];
  assign line      = data_arr[idx];
  assign sel_word  = line[{word, 5'b0} +: 32];
  assign req       = MemRd_i | MemWr_i;
  assign hit       = valid[idx] && (line_tag == req_tag);
  assign store_hit = req && hit && MemWr_i;

  assign stall_o = (state != IDLE) || (req && !hit);
  assign data_o  = (state == IDLE && MemRd_i && hit) ? sel_word : 32'd0;

  assign mem_req_o   = mem_req;
  assign mem_we_o    = mem_we;
  assign mem_addr_o  = mem_addr;
  assign mem_wdata_o = mem_wdata;
  assign hit_cnt_o   = hit_cnt;
  assign miss_cnt_o  = miss_cnt;

  // Memory-port values are computed here and registered, so they are launched on the
  // same edge the FSM leaves IDLE and stay stable until the acknowledging edge.
  always_comb begin
    next_state = state;
    req_n      = mem_req;
    we_n       = mem_we;
    addr_n     = mem_addr;
    wdata_n    = mem_wdata;
    case (state)
      IDLE: begin
        if (req && !hit) begin
          req_n = 1'b1;
          if (valid[idx] && dirty[idx]) begin
            next_state = WBACK;
            we_n       = 1'b1;
            addr_n     = {line_tag, idx, 4'b0};
            wdata_n    = line;
          end else begin
            next_state = ALLOC;
            we_n       = 1'b0;
            addr_n     = {req_tag, idx, 4'b0};
            wdata_n    = '0;
          end
        end
      end
      WBACK: begin
        if (mem_ack_i) begin
          next_state = ALLOC;
          we_n       = 1'b0;
          addr_n     = {req_tag, idx, 4'b0};
          wdata_n    = '0;
        end
      end
      ALLOC: begin
        if (mem_ack_i) begin
          next_state = IDLE;
          req_n      = 1'b0;
          we_n       = 1'b0;
          addr_n     = '0;
          wdata_n    = '0;
        end
      end
      default: begin
        next_state = IDLE;
        req_n      = 1'b0;
        we_n       = 1'b0;
        addr_n     = '0;
        wdata_n    = '0;
      end
    endcase
  end

  // replay marks the single IDLE cycle after a fill, whose hit belongs to the miss already counted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      valid     <= '0;
      dirty     <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      replay    <= 1'b0;
    end else begin
      state     <= next_state;
      mem_req   <= req_n;
      mem_we    <= we_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      replay    <= (state == ALLOC) && mem_ack_i;
      if (state == IDLE && req && hit && !replay && hit_cnt != 32'hFFFF_FFFF)
        hit_cnt <= hit_cnt + 32'd1;
      if (state == IDLE && req && !hit && miss_cnt != 32'hFFFF_FFFF)
        miss_cnt <= miss_cnt + 32'd1;
      if (state == IDLE && store_hit)
        dirty[idx] <= 1'b1;
      else if (state == WBACK && mem_ack_i)
        dirty[idx] <= 1'b0;
      else if (state == ALLOC && mem_ack_i) begin
        dirty[idx] <= 1'b0;
        valid[idx] <= 1'b1;
      end
    end
  end

  // Tag and data storage carries no reset; writes are suppressed while reset is asserted
  // so an aborted fill never lands in the array.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state == IDLE && store_hit)
        data_arr[idx][{word, 5'b0} +: 32] <= data_i;
      else if (state == ALLOC && mem_ack_i) begin
        data_arr[idx] <= mem_rdata_i;
        tag_arr[idx]  <= req_tag;
      end
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl: cold fill, store hits, dirty/clean
// eviction, reset during a fill, spurious ack and simultaneous read/write.
module tb_dcache_ctrl;

  logic         clk;
  logic         rst;
  logic [31:0]  addr;
  logic [31:0]  wdata;
  logic         rd;
  logic         wr;
  logic [31:0]  data_o;
  logic         stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [127:0] mem_wdata_o;
  logic [127:0] mem_rdata;
  logic         mem_ack;
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] LINE_40  = {32'd4, 32'd3, 32'd2, 32'd1};
  localparam logic [127:0] LINE_140 = {32'hA4, 32'hA3, 32'hA2, 32'hA1};
  localparam logic [127:0] LINE_80  = {32'h84, 32'h83, 32'h82, 32'h81};

  dcache_ctrl dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .addr_i     (addr),
    .data_i     (wdata),
    .MemRd_i    (rd),
    .MemWr_i    (wr),
    .data_o     (data_o),
    .stall_o    (stall_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata),
    .mem_ack_i  (mem_ack),
    .hit_cnt_o  (hit_cnt),
    .miss_cnt_o (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Acts as backing memory for one miss: acks the j-th write-back cycle and the k-th fetch
  // cycle, records what the controller asked for, and returns in the first unstalled cycle.
  task automatic serve_miss(input int j, input int k, input logic [127:0] line,
                            output int stalls, output logic saw_wb, output logic first_we,
                            output logic [31:0] wb_addr, output logic [127:0] wb_data,
                            output logic [31:0] fetch_addr, output logic timed_out);
    int  cnt;
    logic seen;
    stalls = 0; saw_wb = 0; first_we = 0; wb_addr = 0; wb_data = 0; fetch_addr = 0;
    timed_out = 1; cnt = 0; seen = 0;
    for (int c = 0; c < 64; c++) begin
      #1;
      if (!stall_o) begin
        timed_out = 0;
        break;
      end
      stalls++;
      if (mem_req_o) begin
        if (!seen) begin
          first_we = mem_we_o;
          seen = 1;
        end
        cnt++;
        if (mem_we_o) begin
          saw_wb = 1; wb_addr = mem_addr_o; wb_data = mem_wdata_o;
          if (cnt == j) begin mem_ack = 1; cnt = 0; end
        end else begin
          fetch_addr = mem_addr_o; mem_rdata = line;
          if (cnt == k) begin mem_ack = 1; cnt = 0; end
        end
      end
      @(negedge clk);
      mem_ack = 0;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1; rd = 0; wr = 0; addr = 0; wdata = 0; mem_ack = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall got %b want 0", stall_o); end
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_req got %b want 0", mem_req_o); end
    checks++; if (mem_we_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_we got %b want 0", mem_we_o); end
    checks++; if (mem_addr_o !== 32'd0) begin errors++; $display("[TB] FAIL reset_addr got %h want 0", mem_addr_o); end
    checks++; if (mem_wdata_o !== 128'd0) begin errors++; $display("[TB] FAIL reset_wdata got %h want 0", mem_wdata_o); end
    checks++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin errors++; $display("[TB] FAIL reset_counters got %0d/%0d want 0/0", hit_cnt, miss_cnt); end
    checks++; if (data_o !== 32'd0) begin errors++; $display("[TB] FAIL reset_data got %h want 0", data_o); end
  endtask

  task automatic test_cold_load();
    int s; logic wb, fwe, to; logic [31:0] wa, fa; logic [127:0] wd;
    @(negedge clk);
    rd = 1; addr = 32'h40;
    #1;
    checks++; if (stall_o !== 1'b1 || mem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL cold_miss_cycle got stall=%b req=%b want 1/0", stall_o, mem_req_o); end
    serve_miss(1, 3, LINE_40, s, wb, fwe, wa, wd, fa, to);
    checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL cold_timeout got %b want 0", to); end
    checks++; if (s !== 4) begin errors++; $display("[TB] FAIL cold_stall_len got %0d want 4", s); end
    checks++; if (fa !== 32'h40 || fwe !== 1'b0 || wb !== 1'b0) begin errors++; $display("[TB] FAIL cold_fetch got addr=%h we=%b wb=%b want 40/0/0", fa, fwe, wb); end
    checks++; if (data_o !== 32'd1) begin errors++; $display("[TB] FAIL cold_data got %h want 1", data_o); end
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL cold_req_drop got %b want 0", mem_req_o); end
    @(negedge clk);
    rd = 0;
    #1;
    checks++; if (miss_cnt !== 32'd1 || hit_cnt !== 32'd0) begin errors++; $display("[TB] FAIL cold_counters got miss=%0d hit=%0d want 1/0", miss_cnt, hit_cnt); end
  endtask

  task automatic test_store_hit();
    @(negedge clk);
    wr = 1; rd = 0; addr = 32'h44; wdata = 32'hDEADBEEF;
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("[TB] FAIL store_hit_stall got %b want 0", stall_o); end
    @(negedge clk);
    wr = 0; rd = 1; addr = 32'h44;
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("[TB] FAIL load_hit_stall got %b want 0", stall_o); end
    checks++; if (data_o !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL load_after_store got %h want deadbeef", data_o); end
    @(negedge clk);
    rd = 0;
    #1;
    checks++; if (hit_cnt !== 32'd2 || miss_cnt !== 32'd1) begin errors++; $display("[TB] FAIL store_counters got hit=%0d miss=%0d want 2/1", hit_cnt, miss_cnt); end
    checks++; if (data_o !== 32'd0) begin errors++; $display("[TB] FAIL idle_data got %h want 0", data_o); end
  endtask

  task automatic test_dirty_eviction();
    int s; logic wb, fwe, to; logic [31:0] wa, fa; logic [127:0] wd;
    @(negedge clk);
    rd = 1; addr = 32'h140;
    serve_miss(2, 3, LINE_140, s, wb, fwe, wa, wd, fa, to);
    checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL dirty_timeout got %b want 0", to); end
    checks++; if (wb !== 1'b1 || fwe !== 1'b1) begin errors++; $display("[TB] FAIL dirty_wback got wb=%b first_we=%b want 1/1", wb, fwe); end
    checks++; if (wa !== 32'h40) begin errors++; $display("[TB] FAIL dirty_wb_addr got %h want 40", wa); end
    checks++; if (wd[63:32] !== 32'hDEADBEEF || wd[31:0] !== 32'd1) begin errors++; $display("[TB] FAIL dirty_wb_data got %h want ..deadbeef_00000001", wd); end
    checks++; if (fa !== 32'h140) begin errors++; $display("[TB] FAIL dirty_fetch_addr got %h want 140", fa); end
    checks++; if (s !== 6) begin errors++; $display("[TB] FAIL dirty_stall_len got %0d want 6", s); end
    checks++; if (data_o !== 32'hA1) begin errors++; $display("[TB] FAIL dirty_data got %h want a1", data_o); end
    @(negedge clk);
    rd = 0;
    #1;
    checks++; if (miss_cnt !== 32'd2 || hit_cnt !== 32'd2) begin errors++; $display("[TB] FAIL dirty_counters got miss=%0d hit=%0d want 2/2", miss_cnt, hit_cnt); end
  endtask

  task automatic test_clean_eviction();
    int s; logic wb, fwe, to; logic [31:0] wa, fa; logic [127:0] wd;
    @(negedge clk);
    rd = 1; addr = 32'h40;
    serve_miss(1, 1, {32'd4, 32'd3, 32'hDEADBEEF, 32'd1}, s, wb, fwe, wa, wd, fa, to);
    checks++; if (to !== 1'b0 || s !== 2) begin errors++; $display("[TB] FAIL clean1_stall got len=%0d to=%b want 2/0", s, to); end
    checks++; if (wb !== 1'b0 || fwe !== 1'b0 || fa !== 32'h40) begin errors++; $display("[TB] FAIL clean1_fetch got wb=%b we=%b addr=%h want 0/0/40", wb, fwe, fa); end
    checks++; if (data_o !== 32'd1) begin errors++; $display("[TB] FAIL clean1_data got %h want 1", data_o); end
    @(negedge clk);
    addr = 32'h140;
    serve_miss(1, 2, LINE_140, s, wb, fwe, wa, wd, fa, to);
    checks++; if (to !== 1'b0 || s !== 3) begin errors++; $display("[TB] FAIL clean2_stall got len=%0d to=%b want 3/0", s, to); end
    checks++; if (wb !== 1'b0 || fwe !== 1'b0 || fa !== 32'h140) begin errors++; $display("[TB] FAIL clean2_fetch got wb=%b we=%b addr=%h want 0/0/140", wb, fwe, fa); end
    checks++; if (data_o !== 32'hA1) begin errors++; $display("[TB] FAIL clean2_data got %h want a1", data_o); end
    @(negedge clk);
    rd = 0;
    #1;
    checks++; if (miss_cnt !== 32'd4 || hit_cnt !== 32'd2) begin errors++; $display("[TB] FAIL clean_counters got miss=%0d hit=%0d want 4/2", miss_cnt, hit_cnt); end
  endtask

  task automatic test_reset_alloc();
    int s; logic wb, fwe, to; logic [31:0] wa, fa; logic [127:0] wd;
    @(negedge clk);
    rd = 1; addr = 32'h80;
    #1;
    checks++; if (stall_o !== 1'b1) begin errors++; $display("[TB] FAIL ra_miss got %b want 1", stall_o); end
    @(negedge clk);
    #1;
    checks++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 32'h80) begin errors++; $display("[TB] FAIL ra_alloc1 got req=%b we=%b addr=%h want 1/0/80", mem_req_o, mem_we_o, mem_addr_o); end
    @(negedge clk);
    rst = 1; mem_ack = 1; mem_rdata = LINE_80;
    @(negedge clk);
    rst = 0; mem_ack = 0;
    #1;
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL ra_req_abort got %b want 0", mem_req_o); end
    checks++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin errors++; $display("[TB] FAIL ra_counters got %0d/%0d want 0/0", hit_cnt, miss_cnt); end
    checks++; if (stall_o !== 1'b1) begin errors++; $display("[TB] FAIL ra_remiss got %b want 1", stall_o); end
    serve_miss(1, 1, LINE_80, s, wb, fwe, wa, wd, fa, to);
    checks++; if (to !== 1'b0 || s !== 2 || fa !== 32'h80) begin errors++; $display("[TB] FAIL ra_refill got len=%0d to=%b addr=%h want 2/0/80", s, to, fa); end
    checks++; if (data_o !== 32'h81) begin errors++; $display("[TB] FAIL ra_data got %h want 81", data_o); end
    @(negedge clk);
    rd = 0;
    #1;
    checks++; if (miss_cnt !== 32'd1 || hit_cnt !== 32'd0) begin errors++; $display("[TB] FAIL ra_counters2 got miss=%0d hit=%0d want 1/0", miss_cnt, hit_cnt); end
  endtask

  task automatic test_spurious_ack();
    @(negedge clk);
    rd = 0; wr = 0; mem_ack = 1; mem_rdata = {128{1'b1}};
    #1;
    checks++; if (stall_o !== 1'b0 || mem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL spur_idle got stall=%b req=%b want 0/0", stall_o, mem_req_o); end
    @(negedge clk);
    mem_ack = 0;
    #1;
    checks++; if (mem_req_o !== 1'b0 || stall_o !== 1'b0) begin errors++; $display("[TB] FAIL spur_after got req=%b stall=%b want 0/0", mem_req_o, stall_o); end
    checks++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd1) begin errors++; $display("[TB] FAIL spur_counters got hit=%0d miss=%0d want 0/1", hit_cnt, miss_cnt); end
    @(negedge clk);
    rd = 1; addr = 32'h80;
    #1;
    checks++; if (stall_o !== 1'b0 || data_o !== 32'h81) begin errors++; $display("[TB] FAIL spur_line_intact got stall=%b data=%h want 0/81", stall_o, data_o); end
    @(negedge clk);
    rd = 0;
    #1;
    checks++; if (hit_cnt !== 32'd1) begin errors++; $display("[TB] FAIL spur_hit_count got %0d want 1", hit_cnt); end
  endtask

  task automatic test_rd_wr_both();
    int s; logic wb, fwe, to; logic [31:0] wa, fa; logic [127:0] wd;
    @(negedge clk);
    rd = 1; addr = 32'h40;
    serve_miss(1, 2, LINE_40, s, wb, fwe, wa, wd, fa, to);
    checks++; if (to !== 1'b0 || s !== 3 || data_o !== 32'd1) begin errors++; $display("[TB] FAIL both_fill got len=%0d data=%h want 3/1", s, data_o); end
    @(negedge clk);
    rd = 1; wr = 1; addr = 32'h48; wdata = 32'h5;
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("[TB] FAIL both_stall got %b want 0", stall_o); end
    @(negedge clk);
    wr = 0; rd = 1; addr = 32'h48;
    #1;
    checks++; if (data_o !== 32'h5) begin errors++; $display("[TB] FAIL both_written got %h want 5", data_o); end
    @(negedge clk);
    addr = 32'h140;
    serve_miss(1, 1, LINE_140, s, wb, fwe, wa, wd, fa, to);
    checks++; if (to !== 1'b0 || wb !== 1'b1 || wa !== 32'h40) begin errors++; $display("[TB] FAIL both_dirty got wb=%b addr=%h want 1/40", wb, wa); end
    checks++; if (wd[95:64] !== 32'h5) begin errors++; $display("[TB] FAIL both_wb_word got %h want 5", wd[95:64]); end
    checks++; if (s !== 3 || data_o !== 32'hA1) begin errors++; $display("[TB] FAIL both_evict got len=%0d data=%h want 3/a1", s, data_o); end
    @(negedge clk);
    rd = 0;
    #1;
    checks++; if (hit_cnt !== 32'd3 || miss_cnt !== 32'd3) begin errors++; $display("[TB] FAIL both_counters got hit=%0d miss=%0d want 3/3", hit_cnt, miss_cnt); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1; rd = 0; wr = 0; addr = 0; wdata = 0; mem_ack = 0; mem_rdata = 0;
    test_reset();
    test_cold_load();
    test_store_hit();
    test_dirty_eviction();
    test_clean_eviction();
    test_reset_alloc();
    test_spurious_ack();
    test_rd_wr_both();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
